// File: rtl/pmbist.sv
// Shared types and geometry for the march-test BIST datapath.
// Optional: define PMBIST_CHECKERBOARD_EN for address-parity data inversion.
package pmbist;

  localparam int ADDR_X     = 2;
  localparam int ADDR_Y     = 2;
  localparam int ADDR_X_MAX = (1 << ADDR_X) - 1;
  localparam int ADDR_Y_MAX = (1 << ADDR_Y) - 1;
  localparam int BG_DATA    = 8;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } t_op_cmd;

  typedef struct packed {
    logic wr;
    logic inv;
  } t_march_op;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_RUN,
    MS_DONE
  } t_mseq_state;

  function automatic t_op_cmd f_cmd(input t_march_op op);
    return op.wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mseq_addr_cnt.sv
// One address axis: up/down counter with load, step and terminal flag.
// o_wrap is high while the count sits at the end of its travel.
module mseq_addr_cnt #(
  parameter int W   = 2,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic         i_down,
  input  logic         i_step,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  localparam logic [W-1:0] L_MAX = W'(MAX);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_nxt;
  logic         w_term;

  assign w_term = i_down ? (r_cnt == '0)
                         : (r_cnt == L_MAX);

  always_comb begin
    w_nxt = r_cnt;
    if (w_term)
      w_nxt = i_down ? L_MAX : '0;
    else if (i_down)
      w_nxt = r_cnt - W'(1);
    else
      w_nxt = r_cnt + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_down ? L_MAX : '0;
    else if (i_step)
      r_cnt <= w_nxt;
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = w_term;

endmodule

// File: rtl/march_elem_seq.sv
// Runs one march element: per address, nops+1 ops with X/Y and data.
// Optional: PMBIST_CHECKERBOARD_EN adds address-parity data inversion.
module march_elem_seq
  import pmbist::*;
#(
  parameter int MAX_OPS = 4,
  parameter int OPW     = $clog2(MAX_OPS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [OPW-1:0]       i_elem_nops,
  input  logic [2*MAX_OPS-1:0] i_elem_ops,
  input  logic                 i_addr_down,
  input  logic                 i_y_fast,
  input  logic [BG_DATA-1:0]   i_bg,
  output t_op_cmd              o_op_cmd,
  output logic [ADDR_X-1:0]    o_addr_x,
  output logic [ADDR_Y-1:0]    o_addr_y,
  output logic [BG_DATA-1:0]   o_data,
  output logic                 o_busy,
  output logic                 o_done
);

  t_mseq_state          r_state;
  logic [OPW-1:0]       r_nops;
  logic [OPW-1:0]       r_opi;
  logic [2*MAX_OPS-1:0] r_ops;
  logic                 r_down;
  logic                 r_yfast;
  logic [BG_DATA-1:0]   r_bg;

  logic               w_run;
  logic               w_cap;
  logic               w_cnt_down;
  logic               w_op_end;
  logic               w_last;
  logic               w_adv;
  logic               w_step_x;
  logic               w_step_y;
  logic               w_x_wrap;
  logic               w_y_wrap;
  logic [OPW-1:0]     w_opi_nx;
  t_march_op          w_op_nx;
  t_march_op          w_op_first;
  logic [BG_DATA-1:0] w_data_nx;
  logic [BG_DATA-1:0] w_data_first;

  assign w_run      = (r_state == MS_RUN);
  assign w_cap      = (r_state == MS_IDLE) && i_start && !i_abort;
  assign w_cnt_down = w_cap ? i_addr_down : r_down;
  assign w_op_end   = (r_opi == r_nops);
  assign w_last     = w_run && w_op_end && w_x_wrap && w_y_wrap;
  assign w_adv      = w_run && !i_abort && !w_last && w_op_end;

  // Fast axis steps on every op wrap; slow axis only when fast wraps
  assign w_step_x = w_adv && (r_yfast ? w_y_wrap : 1'b1);
  assign w_step_y = w_adv && (r_yfast ? 1'b1 : w_x_wrap);

  assign w_opi_nx   = w_op_end ? '0 : r_opi + OPW'(1);
  assign w_op_nx    = t_march_op'(r_ops[{w_opi_nx, 1'b0} +: 2]);
  assign w_op_first = t_march_op'(i_elem_ops[1:0]);

`ifdef PMBIST_CHECKERBOARD_EN
  // Axis maxima are all-ones, so any step (wrap included) flips bit 0
  localparam logic L_PAR_HI = 1'(ADDR_X_MAX) ^ 1'(ADDR_Y_MAX);
  logic w_par_nx;
  logic w_par_first;
  assign w_par_nx = o_addr_x[0] ^ o_addr_y[0]
                  ^ w_step_x ^ w_step_y;
  assign w_par_first = i_addr_down & L_PAR_HI;
  assign w_data_nx = r_bg ^ {BG_DATA{w_op_nx.inv}}
                   ^ {BG_DATA{w_par_nx}};
  assign w_data_first = i_bg ^ {BG_DATA{w_op_first.inv}}
                      ^ {BG_DATA{w_par_first}};
`else
  assign w_data_nx    = r_bg ^ {BG_DATA{w_op_nx.inv}};
  assign w_data_first = i_bg ^ {BG_DATA{w_op_first.inv}};
`endif

  mseq_addr_cnt #(
    .W   (ADDR_X),
    .MAX (ADDR_X_MAX)
  ) u_cnt_x (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_cap),
    .i_down (w_cnt_down),
    .i_step (w_step_x),
    .o_cnt  (o_addr_x),
    .o_wrap (w_x_wrap)
  );

  mseq_addr_cnt #(
    .W   (ADDR_Y),
    .MAX (ADDR_Y_MAX)
  ) u_cnt_y (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_cap),
    .i_down (w_cnt_down),
    .i_step (w_step_y),
    .o_cnt  (o_addr_y),
    .o_wrap (w_y_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= MS_IDLE;
      r_nops   <= '0;
      r_opi    <= '0;
      r_ops    <= '0;
      r_down   <= 1'b0;
      r_yfast  <= 1'b0;
      r_bg     <= '0;
      o_op_cmd <= OP_NOP;
      o_data   <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      unique case (r_state)
        MS_IDLE: begin
          o_done   <= 1'b0;
          o_op_cmd <= OP_NOP;
          if (w_cap) begin
            r_state  <= MS_RUN;
            r_nops   <= i_elem_nops;
            r_ops    <= i_elem_ops;
            r_down   <= i_addr_down;
            r_yfast  <= i_y_fast;
            r_bg     <= i_bg;
            r_opi    <= '0;
            o_op_cmd <= f_cmd(w_op_first);
            o_data   <= w_data_first;
            o_busy   <= 1'b1;
          end
        end
        MS_RUN: begin
          if (i_abort) begin
            r_state  <= MS_IDLE;
            o_op_cmd <= OP_NOP;
            o_busy   <= 1'b0;
          end else if (w_last) begin
            r_state  <= MS_DONE;
            o_op_cmd <= OP_NOP;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
          end else begin
            r_opi    <= w_opi_nx;
            o_op_cmd <= f_cmd(w_op_nx);
            o_data   <= w_data_nx;
          end
        end
        MS_DONE: begin
          r_state  <= MS_IDLE;
          o_done   <= 1'b0;
          o_op_cmd <= OP_NOP;
        end
        default: begin
          r_state  <= MS_IDLE;
          o_op_cmd <= OP_NOP;
          o_busy   <= 1'b0;
          o_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_march_elem_seq.sv
// Directed bench for march_elem_seq with a 4x4 address array.
// Define PMBIST_CHECKERBOARD_EN to exercise the checkerboard data path.
module tb_march_elem_seq;
  import pmbist::*;

  logic       clk;
  logic       rstn;
  logic       i_start;
  logic       i_abort;
  logic [1:0] i_elem_nops;
  logic [7:0] i_elem_ops;
  logic       i_addr_down;
  logic       i_y_fast;
  logic [7:0] i_bg;
  t_op_cmd    o_op_cmd;
  logic [1:0] o_addr_x;
  logic [1:0] o_addr_y;
  logic [7:0] o_data;
  logic       o_busy;
  logic       o_done;

  int total;
  int bad;

  march_elem_seq #(.MAX_OPS(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_elem_nops (i_elem_nops),
    .i_elem_ops  (i_elem_ops),
    .i_addr_down (i_addr_down),
    .i_y_fast    (i_y_fast),
    .i_bg        (i_bg),
    .o_op_cmd    (o_op_cmd),
    .o_addr_x    (o_addr_x),
    .o_addr_y    (o_addr_y),
    .o_data      (o_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_data(
    input logic [7:0] bg,
    input logic       inv,
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic [7:0] d;
    d = bg ^ {8{inv}};
`ifdef PMBIST_CHECKERBOARD_EN
    d = d ^ {8{x[0] ^ y[0]}};
`endif
    return d;
  endfunction

  task automatic start_elem(
    input logic [1:0] nops,
    input logic [7:0] ops,
    input logic       down,
    input logic       yf,
    input logic [7:0] bg
  );
    @(negedge clk);
    i_elem_nops = nops;
    i_elem_ops  = ops;
    i_addr_down = down;
    i_y_fast    = yf;
    i_bg        = bg;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (o_op_cmd !== OP_NOP || o_addr_x !== 2'd0 ||
        o_addr_y !== 2'd0 || o_data !== 8'h00 ||
        o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL reset: cmd=%0d x=%0d y=%0d d=%h b=%b dn=%b want 0s",
               o_op_cmd, o_addr_x, o_addr_y, o_data, o_busy, o_done);
    end
    rstn = 1'b1;
  endtask

  // Ascending, X fast, {W0,R0}, bg 55; optional re-pulse of start mid-run
  task automatic run_asc(input bit repulse);
    t_op_cmd    ec;
    logic [1:0] ex, ey;
    logic [7:0] ed;
    start_elem(2'd1, 8'b0000_0010, 1'b0, 1'b0, 8'h55);
    for (int i = 0; i < 32; i++) begin
      ec = (i % 2 == 0) ? OP_WRITE : OP_READ;
      ex = 2'((i / 2) % 4);
      ey = 2'(i / 8);
      ed = exp_data(8'h55, 1'b0, ex, ey);
      total++;
      if (o_op_cmd !== ec || o_addr_x !== ex || o_addr_y !== ey ||
          o_data !== ed || o_busy !== 1'b1 || o_done !== 1'b0) begin
        bad++;
        $display("FAIL asc[%0d]: cmd=%0d x=%0d y=%0d d=%h b=%b dn=%b want cmd=%0d x=%0d y=%0d d=%h b=1 dn=0",
                 i, o_op_cmd, o_addr_x, o_addr_y, o_data, o_busy, o_done,
                 ec, ex, ey, ed);
      end
      if (repulse && i == 9) begin
        i_start     = 1'b1;
        i_addr_down = 1'b1;
        i_bg        = 8'hAA;
        i_elem_nops = 2'd0;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_op_cmd !== OP_NOP) begin
      bad++;
      $display("FAIL asc_done: dn=%b b=%b cmd=%0d want dn=1 b=0 cmd=0",
               o_done, o_busy, o_op_cmd);
    end
    @(negedge clk);
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL asc_idle: dn=%b b=%b want 0 0", o_done, o_busy);
    end
  endtask

  task automatic test_ascending;
    run_asc(1'b0);
  endtask

  task automatic test_restart_ignored;
    run_asc(1'b1);
  endtask

  task automatic test_descending;
    logic [1:0] ex, ey;
    logic [7:0] ed;
    start_elem(2'd0, 8'b0000_0001, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      ey = 2'(3 - (i % 4));
      ex = 2'(3 - (i / 4));
      ed = exp_data(8'h00, 1'b1, ex, ey);
      total++;
      if (o_op_cmd !== OP_READ || o_addr_x !== ex || o_addr_y !== ey ||
          o_data !== ed || o_busy !== 1'b1) begin
        bad++;
        $display("FAIL desc[%0d]: cmd=%0d x=%0d y=%0d d=%h b=%b want cmd=2 x=%0d y=%0d d=%h b=1",
                 i, o_op_cmd, o_addr_x, o_addr_y, o_data, o_busy,
                 ex, ey, ed);
      end
      @(negedge clk);
    end
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_op_cmd !== OP_NOP) begin
      bad++;
      $display("FAIL desc_done: dn=%b b=%b cmd=%0d want dn=1 b=0 cmd=0",
               o_done, o_busy, o_op_cmd);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int seen;
    start_elem(2'd1, 8'b0000_0010, 1'b0, 1'b0, 8'h55);
    repeat (4) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    total++;
    if (o_op_cmd !== OP_NOP || o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_addr_x !== 2'd2 || o_addr_y !== 2'd0) begin
      bad++;
      $display("FAIL abort: cmd=%0d b=%b dn=%b x=%0d y=%0d want 0 0 0 2 0",
               o_op_cmd, o_busy, o_done, o_addr_x, o_addr_y);
    end
    seen = 0;
    repeat (6) begin
      if (o_done !== 1'b0 || o_busy !== 1'b0) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_quiet: active_cycles=%0d want 0", seen);
    end
    run_asc(1'b0);
  endtask

  task automatic test_abort_on_last;
    start_elem(2'd0, 8'b0000_0001, 1'b1, 1'b1, 8'h00);
    repeat (15) @(negedge clk);
    total++;
    if (o_addr_x !== 2'd0 || o_addr_y !== 2'd0 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL last_pos: x=%0d y=%0d b=%b want 0 0 1",
               o_addr_x, o_addr_y, o_busy);
    end
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_op_cmd !== OP_NOP) begin
      bad++;
      $display("FAIL abort_last: dn=%b b=%b cmd=%0d want 0 0 0",
               o_done, o_busy, o_op_cmd);
    end
    @(negedge clk);
    total++;
    if (o_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_last_late: dn=%b want 0", o_done);
    end
  endtask

  task automatic test_start_abort_idle;
    @(negedge clk);
    i_elem_nops = 2'd0;
    i_elem_ops  = 8'b0000_0010;
    i_addr_down = 1'b0;
    i_y_fast    = 1'b0;
    i_start     = 1'b1;
    i_abort     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_op_cmd !== OP_NOP) begin
      bad++;
      $display("FAIL start_abort_idle: b=%b cmd=%0d want 0 0",
               o_busy, o_op_cmd);
    end
  endtask

  task automatic test_midrun_reset;
    int seen;
    start_elem(2'd1, 8'b0000_0010, 1'b0, 1'b0, 8'h55);
    repeat (7) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    total++;
    if (o_op_cmd !== OP_NOP || o_addr_x !== 2'd0 ||
        o_addr_y !== 2'd0 || o_data !== 8'h00 ||
        o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: cmd=%0d x=%0d y=%0d d=%h b=%b dn=%b want 0s",
               o_op_cmd, o_addr_x, o_addr_y, o_data, o_busy, o_done);
    end
    seen = 0;
    repeat (40) begin
      if (o_done !== 1'b0 || o_busy !== 1'b0) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midrun_quiet: active_cycles=%0d want 0", seen);
    end
  endtask

`ifdef PMBIST_CHECKERBOARD_EN
  task automatic test_checkerboard;
    logic [7:0] want [16];
    for (int i = 0; i < 16; i++)
      want[i] = (((i % 4) + (i / 4)) % 2 == 1) ? 8'hFF : 8'h00;
    start_elem(2'd0, 8'b0000_0010, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (o_data !== want[i] || o_op_cmd !== OP_WRITE) begin
        bad++;
        $display("FAIL checker[%0d]: d=%h cmd=%0d want d=%h cmd=1",
                 i, o_data, o_op_cmd, want[i]);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    total       = 0;
    bad         = 0;
    rstn        = 1'b0;
    i_start     = 1'b0;
    i_abort     = 1'b0;
    i_elem_nops = '0;
    i_elem_ops  = '0;
    i_addr_down = 1'b0;
    i_y_fast    = 1'b0;
    i_bg        = '0;
    test_reset();
    test_ascending();
    test_descending();
    test_abort();
    test_abort_on_last();
    test_start_abort_idle();
    test_restart_ignored();
    test_midrun_reset();
`ifdef PMBIST_CHECKERBOARD_EN
    test_checkerboard();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
